// File: rtl/generador_dpwm_10b.sv
// -----------------------------------------------------------------------------
// generador_dpwm_10b
//   10-bit digital PWM modulator. A prescaler divides clk into counter ticks,
//   and a 10-bit period counter runs 0..1023, so one period is 1024 ticks. The
//   duty value is taken from cant_corriente only when the counter wraps. This
//   keeps every period glitch-free, even if the upstream value changes
//   mid-period.
//
//   Parameters
//     PRESCALER  clock cycles per counter tick, 1..16
//     DUTY_MAX   upper duty clamp, only used when DPWM_LIMITE_EN is defined
//
//   Optional feature (macro DPWM_LIMITE_EN)
//     When defined, the duty loaded at wrap is min(cant_corriente, DUTY_MAX).
//     When undefined, cant_corriente is loaded unmodified.
//
//   Ports
//     clk             system clock; every state change is on the rising edge
//     reset           synchronous, active-high
//     enable          1 = run; 0 = freeze counters and force pwm_out low
//     cant_corriente  requested duty, in counts out of 1024
//     pwm_out         registered PWM output, one clock behind the compare
//     fin_periodo     single-clock pulse on the clock after a period wrap
//     duty_activo     duty in use for the current period (shadow register)
// -----------------------------------------------------------------------------
module generador_dpwm_10b #(
    parameter int PRESCALER = 1,
    parameter int DUTY_MAX  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] cant_corriente,
    output logic       pwm_out,
    output logic       fin_periodo,
    output logic [9:0] duty_activo
);

    // Catch illegal parameter values when the design is elaborated.
    if (PRESCALER < 1 || PRESCALER > 16) begin : g_bad_prescaler
        $error("generador_dpwm_10b: PRESCALER must be in 1..16");
    end
    if (DUTY_MAX < 0 || DUTY_MAX > 1023) begin : g_bad_duty_max
        $error("generador_dpwm_10b: DUTY_MAX must be in 0..1023");
    end

    localparam logic [3:0] PRE_ULTIMO = 4'(PRESCALER - 1);

    logic [3:0] prescaler;
    logic [9:0] contador;
    logic       tick;
    logic       wrap;
    logic [9:0] duty_sig;

    // A tick needs enable, so a paused modulator freezes both counters in place.
    assign tick = enable && (prescaler == PRE_ULTIMO);
    assign wrap = tick && (contador == 10'd1023);

`ifdef DPWM_LIMITE_EN
    localparam logic [9:0] DUTY_LIM = 10'(DUTY_MAX);
    assign duty_sig = (cant_corriente > DUTY_LIM) ? DUTY_LIM : cant_corriente;
`else
    assign duty_sig = cant_corriente;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler   <= 4'd0;
            contador    <= 10'd0;
            duty_activo <= 10'd0;
            pwm_out     <= 1'b0;
            fin_periodo <= 1'b0;
        end else begin
            if (enable)
                prescaler <= tick ? 4'd0 : prescaler + 4'd1;
            // 1023 + 1 overflows to 0 in 10 bits, which gives the period wrap.
            if (tick)
                contador <= contador + 10'd1;
            if (wrap)
                duty_activo <= duty_sig;
            fin_periodo <= wrap;
            // Compare against the pre-edge shadow duty. For the clock right
            // after a wrap, the old value is used with contador=1023. That
            // compare is always false, so the new duty shows up cleanly.
            pwm_out <= enable && (contador < duty_activo);
        end
    end

endmodule

// File: tb/tb_generador_dpwm_10b.sv
module tb_generador_dpwm_10b;

`ifdef DPWM_LIMITE_EN
    localparam int LIM1020 = 1000;
`else
    localparam int LIM1020 = 1020;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, pwm_a, fin_a;
    logic [9:0] cant_a, duty_a;
    logic       rst_b, en_b, pwm_b, fin_b;
    logic [9:0] cant_b, duty_b;

    generador_dpwm_10b #(.PRESCALER(1), .DUTY_MAX(1000)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .cant_corriente(cant_a),
        .pwm_out(pwm_a), .fin_periodo(fin_a), .duty_activo(duty_a)
    );

    generador_dpwm_10b #(.PRESCALER(4), .DUTY_MAX(1000)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .cant_corriente(cant_b),
        .pwm_out(pwm_b), .fin_periodo(fin_b), .duty_activo(duty_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard entry for one period, counted from one fin_periodo pulse to the next.
    typedef struct {
        int len;
        int high;
    } win_t;
    win_t q_a[$];
    win_t q_b[$];

    task automatic tk(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fin_a(input string tag);
        int c = 0;
        do begin tk(); c++; end while (fin_a !== 1'b1 && c < 5000);
        chk(tag, fin_a, 1);
    endtask

    task automatic wait_fin_b(input string tag);
        int c = 0;
        do begin tk(); c++; end while (fin_b !== 1'b1 && c < 5000);
        chk(tag, fin_b, 1);
    endtask

    // Monitor A: measure each period, and check that the duty changes only on the wrap clock.
    initial begin
        int   len = 0, hi = 0;
        bit   open = 0;
        logic rst_q = 1'b1;
        logic [9:0] duty_q = 10'd0;
        win_t w;
        forever begin
            @(negedge clk);
            if (!rst_q && duty_a !== duty_q)
                chk("a_duty_change_on_wrap", fin_a, 1);
            duty_q = duty_a;
            rst_q  = rst_a;
            if (rst_a) begin
                open = 0;
                q_a.delete();
            end else if (fin_a) begin
                if (open) begin
                    if (q_a.size() == 0) chk("a_sb_underflow", 0, 1);
                    else begin
                        w = q_a.pop_front();
                        chk("a_period_len", len, w.len);
                        chk("a_high_cnt", hi, w.high);
                    end
                end
                open = 1; len = 1; hi = int'(pwm_a);
            end else if (open) begin
                len++;
                hi += int'(pwm_a);
            end
        end
    end

    // Monitor B: period and high-time measurement for the prescaled instance.
    initial begin
        int   len = 0, hi = 0;
        bit   open = 0;
        win_t w;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                open = 0;
                q_b.delete();
            end else if (fin_b) begin
                if (open) begin
                    if (q_b.size() == 0) chk("b_sb_underflow", 0, 1);
                    else begin
                        w = q_b.pop_front();
                        chk("b_period_len", len, w.len);
                        chk("b_high_cnt", hi, w.high);
                    end
                end
                open = 1; len = 1; hi = int'(pwm_b);
            end else if (open) begin
                len++;
                hi += int'(pwm_b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b0; cant_a = 10'd256;
        rst_b = 1'b1; en_b = 1'b1; cant_b = 10'd10;
        fork
            begin : seq_a
                tk(3);
                chk("a_rst_pwm", pwm_a, 0);
                chk("a_rst_fin", fin_a, 0);
                chk("a_rst_duty", duty_a, 0);
                rst_a = 1'b0; en_a = 1'b1;
                // Period 1: duty 256; change the request mid-period.
                wait_fin_a("a_wrap1");
                chk("a_duty_w1", duty_a, 256);
                q_a.push_back('{1024, 256});
                tk(300); cant_a = 10'd512; tk(1);
                chk("a_duty_hold_midchange", duty_a, 256);
                // Period 2: duty 512, with a 50-clock pause at contador=100.
                wait_fin_a("a_wrap2");
                chk("a_duty_w2", duty_a, 512);
                q_a.push_back('{1074, 512});
                tk(100);
                chk("a_pwm_hi_pre_pause", pwm_a, 1);
                en_a = 1'b0; tk(1);
                chk("a_pause_pwm", pwm_a, 0);
                chk("a_pause_fin", fin_a, 0);
                tk(49);
                chk("a_pause_pwm_end", pwm_a, 0);
                chk("a_pause_duty", duty_a, 512);
                en_a = 1'b1;
                tk(10); cant_a = 10'd0;
                // Period 3: duty 0.
                wait_fin_a("a_wrap3");
                chk("a_duty_w3", duty_a, 0);
                q_a.push_back('{1024, 0});
                tk(200); cant_a = 10'd1023;
                // Period 4: duty 1023.
                wait_fin_a("a_wrap4");
                chk("a_duty_w4", duty_a, 1023);
                q_a.push_back('{1024, 1023});
                tk(200); cant_a = 10'd1020;
                // Period 5: request 1020 (clamped when the limit is built in).
                wait_fin_a("a_wrap5");
                chk("a_duty_w5", duty_a, LIM1020);
                q_a.push_back('{1024, LIM1020});
                // Period 6: reset mid-period.
                wait_fin_a("a_wrap6");
                tk(500);
                chk("a_pwm_hi_pre_reset", pwm_a, 1);
                rst_a = 1'b1; tk(1);
                chk("a_midrst_pwm", pwm_a, 0);
                chk("a_midrst_fin", fin_a, 0);
                chk("a_midrst_duty", duty_a, 0);
                // A wrap that coincides with reset must neither load nor pulse.
                cant_a = 10'd300; tk(1);
                rst_a = 1'b0; tk(1023);
                chk("a_first_period_duty", duty_a, 0);
                chk("a_first_period_pwm", pwm_a, 0);
                chk("a_first_period_fin", fin_a, 0);
                rst_a = 1'b1; tk(1);
                chk("a_rst_wrap_fin", fin_a, 0);
                chk("a_rst_wrap_duty", duty_a, 0);
            end
            begin : seq_b
                tk(2);
                chk("b_rst_pwm", pwm_b, 0);
                chk("b_rst_fin", fin_b, 0);
                rst_b = 1'b0;
                wait_fin_b("b_wrap1");
                chk("b_duty_w1", duty_b, 10);
                q_b.push_back('{4096, 40});
                wait_fin_b("b_wrap2");
                q_b.push_back('{4096, 40});
                wait_fin_b("b_wrap3");
            end
        join
        tk(2);
        chk("a_sb_empty", q_a.size(), 0);
        chk("b_sb_empty", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
